// File: rtl/reglk_pkg.sv
// Shared types and constants for the register-lock access controller.
//   NUM_REGS_DEF  : default number of protected registers
//   LCK_BIT       : bit position of the lock / override flag in each lock word
//   reglk_state_e : request FSM states
//   reglk_rsp_t   : response payload (read data + error)
package reglk_pkg;

    localparam int unsigned NUM_REGS_DEF = 6;
    localparam int unsigned LCK_BIT      = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } reglk_state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } reglk_rsp_t;

endpackage

// File: rtl/reglk_viol_counter.sv
// Saturating lock-violation counter with a sticky "any violation" flag.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (clears count and flag)
//   inc_i  : one violation this cycle
//   cnt_o  : violation count, holds at all-ones
//   flag_o : set by the first violation, cleared only by reset
module reglk_viol_counter
    import reglk_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             flag_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (inc_i) begin
            flag_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/reglk_access_ctrl.sv
// Bus-facing gatekeeper for a bank of protected 32-bit registers.
// Writes land only when the register's lock bit is clear, or when a debug
// session is active and the register's JTAG override bit is set. Every
// accepted request gets exactly one response; locked write attempts are
// counted.
//   clk_i / rst_i         : clock, synchronous active-high reset
//   reglk_mem             : per-register lock words (bit LCK_BIT = write-protect)
//   jtag_unlock           : per-register debug override words (bit LCK_BIT)
//   dbg_i                 : debug session active, captured with the request
//   req_valid_i/ready_o   : request handshake; we/addr/wdata payload
//   rsp_valid_o/ready_i   : response handshake; rdata/err payload
//   regs_o                : current register contents
//   viol_cnt_o/flag_o     : saturating violation count, sticky violation flag
module reglk_access_ctrl
    import reglk_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter logic [31:0] REG_RST  = 32'h0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REGS-1:0][31:0] reglk_mem,
    input  logic [NUM_REGS-1:0][31:0] jtag_unlock,
    input  logic                     dbg_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [2:0]               req_addr_i,
    input  logic [31:0]              req_wdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [31:0]              rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic [NUM_REGS-1:0][31:0] regs_o,
    output logic [CNT_W-1:0]         viol_cnt_o,
    output logic                     viol_flag_o
);

    reglk_state_e              state_q;
    logic                      we_q;
    logic                      dbg_q;
    logic [2:0]                addr_q;
    logic [31:0]               wdata_q;
    logic [NUM_REGS-1:0][31:0] regs_q;
    reglk_rsp_t                rsp_q, rsp_d;
    logic                      rsp_valid_q;

    logic                      in_range;
    logic                      lock_bit;
    logic                      ovr_bit;
    logic                      permit;
    logic                      wr_en;
    logic                      viol_inc;
    logic [31:0]               rd_word;

    // Only LCK_BIT of each lock/override word is meaningful.
    logic unused_lock_bits;
    assign unused_lock_bits = ^{reglk_mem, jtag_unlock};

    // Request evaluation. The index loop keeps out-of-range addresses from
    // ever selecting an array element; such requests see lock_bit = 0 but
    // are rejected by in_range first.
    always_comb begin
        in_range = (32'(addr_q) < NUM_REGS);
        rd_word  = '0;
        lock_bit = 1'b0;
        ovr_bit  = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(addr_q) == i) begin
                rd_word  = regs_q[i];
                lock_bit = reglk_mem[i][LCK_BIT];
                ovr_bit  = jtag_unlock[i][LCK_BIT];
            end
        end
        permit   = !lock_bit || (dbg_q && ovr_bit);

        rsp_d    = '0;
        wr_en    = 1'b0;
        viol_inc = 1'b0;
        if (state_q == CHECK) begin
            if (!in_range) begin
                rsp_d.err = 1'b1;
            end else if (!we_q) begin
                rsp_d.rdata = rd_word;
            end else if (permit) begin
                wr_en = 1'b1;
            end else begin
                rsp_d.err = 1'b1;
                viol_inc  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            dbg_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            regs_q      <= {NUM_REGS{REG_RST}};
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        dbg_q   <= dbg_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (wr_en && (32'(addr_q) == i)) begin
                            regs_q[i] <= wdata_q;
                        end
                    end
                    rsp_q       <= rsp_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_q       <= '0;
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    reglk_viol_counter #(
        .CNT_W (CNT_W)
    ) u_viol_counter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (viol_inc),
        .cnt_o  (viol_cnt_o),
        .flag_o (viol_flag_o)
    );

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;
    assign regs_o      = regs_q;

endmodule

// File: tb/tb_reglk_access_ctrl.sv
module tb_reglk_access_ctrl;

    logic              clk;
    logic              rst_i;
    logic [5:0][31:0]  reglk_mem;
    logic [5:0][31:0]  jtag_unlock;
    logic              dbg_i;
    logic              req_valid_i;
    logic              req_we_i;
    logic [2:0]        req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_ready_i;

    logic              req_ready_o;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic [5:0][31:0]  regs_o;
    logic [15:0]       viol_cnt_o;
    logic              viol_flag_o;

    logic              s_req_ready;
    logic              s_rsp_valid;
    logic [31:0]       s_rsp_rdata;
    logic              s_rsp_err;
    logic [5:0][31:0]  s_regs;
    logic [1:0]        s_cnt;
    logic              s_flag;

    logic [5:0][31:0]  exp_regs;
    int                checks;
    int                failures;

    reglk_access_ctrl #(
        .NUM_REGS (6),
        .REG_RST  (32'h0),
        .CNT_W    (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .reglk_mem   (reglk_mem),
        .jtag_unlock (jtag_unlock),
        .dbg_i       (dbg_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .regs_o      (regs_o),
        .viol_cnt_o  (viol_cnt_o),
        .viol_flag_o (viol_flag_o)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    reglk_access_ctrl #(
        .NUM_REGS (6),
        .REG_RST  (32'h0),
        .CNT_W    (2)
    ) dut_sat (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .reglk_mem   (reglk_mem),
        .jtag_unlock (jtag_unlock),
        .dbg_i       (dbg_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (s_req_ready),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (s_rsp_valid),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (s_rsp_rdata),
        .rsp_err_o   (s_rsp_err),
        .regs_o      (s_regs),
        .viol_cnt_o  (s_cnt),
        .viol_flag_o (s_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for ready, presents one request, returns #1 after E1.
    task automatic issue(input logic we, input logic [2:0] addr, input logic [31:0] wd);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready_wait got=%b exp=1", req_ready_o);
        end
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    // Accepts the pending response and checks the return to IDLE.
    task automatic complete_rsp;
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rsp_drop got=%b exp=0", rsp_valid_o);
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ready_back got=%b exp=1", req_ready_o);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        checks++;
        if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready_o); end
        checks++;
        if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid_o); end
        checks++;
        if ({rsp_rdata_o, rsp_err_o} !== 33'h0) begin failures++; $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_rdata_o, rsp_err_o); end
        checks++;
        if (regs_o !== exp_regs) begin failures++; $display("FAIL rst_regs got=%h exp=%h", regs_o, exp_regs); end
        checks++;
        if (viol_cnt_o !== 16'd0 || viol_flag_o !== 1'b0) begin failures++; $display("FAIL rst_viol got=%0d/%b exp=0/0", viol_cnt_o, viol_flag_o); end
    endtask

    task automatic test_read_after_reset;
        issue(1'b0, 3'd2, 32'h0);
        checks++;
        if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL rd2_valid got=%b exp=1", rsp_valid_o); end
        checks++;
        if (rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin failures++; $display("FAIL rd2_rsp got=%h/%b exp=0/0", rsp_rdata_o, rsp_err_o); end
        checks++;
        if (req_ready_o !== 1'b0) begin failures++; $display("FAIL rd2_busy got=%b exp=0", req_ready_o); end
        complete_rsp();
    endtask

    task automatic test_write_unlocked;
        issue(1'b1, 3'd3, 32'hDEADBEEF);
        exp_regs[3] = 32'hDEADBEEF;
        checks++;
        if (regs_o !== exp_regs) begin failures++; $display("FAIL wr3_regs got=%h exp=%h", regs_o, exp_regs); end
        checks++;
        if (rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL wr3_rsp got=%h/%b exp=0/0", rsp_rdata_o, rsp_err_o); end
        checks++;
        if (viol_cnt_o !== 16'd0) begin failures++; $display("FAIL wr3_cnt got=%0d exp=0", viol_cnt_o); end
        complete_rsp();
        // Bits above the lock bit must be ignored.
        reglk_mem[3] = 32'hFFFF_FFFE;
        issue(1'b1, 3'd3, 32'hCAFEF00D);
        exp_regs[3] = 32'hCAFEF00D;
        checks++;
        if (regs_o !== exp_regs || rsp_err_o !== 1'b0) begin failures++; $display("FAIL wr3_hibits got=%h/%b exp=%h/0", regs_o, rsp_err_o, exp_regs); end
        complete_rsp();
        issue(1'b0, 3'd3, 32'h0);
        checks++;
        if (rsp_rdata_o !== 32'hCAFEF00D || rsp_err_o !== 1'b0) begin failures++; $display("FAIL rd3 got=%h/%b exp=cafef00d/0", rsp_rdata_o, rsp_err_o); end
        complete_rsp();
    endtask

    task automatic test_locked_write;
        reglk_mem[1]   = 32'h1;
        jtag_unlock[1] = 32'h1;
        dbg_i          = 1'b0;
        issue(1'b1, 3'd1, 32'h1234);
        checks++;
        if (regs_o !== exp_regs) begin failures++; $display("FAIL lk_regs got=%h exp=%h", regs_o, exp_regs); end
        checks++;
        if (rsp_err_o !== 1'b1) begin failures++; $display("FAIL lk_err got=%b exp=1", rsp_err_o); end
        checks++;
        if (viol_cnt_o !== 16'd1 || viol_flag_o !== 1'b1) begin failures++; $display("FAIL lk_viol got=%0d/%b exp=1/1", viol_cnt_o, viol_flag_o); end
        complete_rsp();

        dbg_i = 1'b1;
        issue(1'b1, 3'd1, 32'h1234);
        exp_regs[1] = 32'h1234;
        checks++;
        if (regs_o !== exp_regs || rsp_err_o !== 1'b0) begin failures++; $display("FAIL ovr_write got=%h/%b exp=%h/0", regs_o, rsp_err_o, exp_regs); end
        checks++;
        if (viol_cnt_o !== 16'd1) begin failures++; $display("FAIL ovr_cnt got=%0d exp=1", viol_cnt_o); end
        complete_rsp();

        // Debug alone is not enough without the per-register override.
        jtag_unlock[1] = 32'hFFFF_FFFE;
        issue(1'b1, 3'd1, 32'h9999);
        checks++;
        if (regs_o !== exp_regs || rsp_err_o !== 1'b1) begin failures++; $display("FAIL noovr got=%h/%b exp=%h/1", regs_o, rsp_err_o, exp_regs); end
        checks++;
        if (viol_cnt_o !== 16'd2 || s_cnt !== 2'd2) begin failures++; $display("FAIL noovr_cnt got=%0d/%0d exp=2/2", viol_cnt_o, s_cnt); end
        complete_rsp();
        dbg_i = 1'b0;

        // Reads of a locked register are always allowed.
        issue(1'b0, 3'd1, 32'h0);
        checks++;
        if (rsp_rdata_o !== 32'h1234 || rsp_err_o !== 1'b0) begin failures++; $display("FAIL rd_locked got=%h/%b exp=1234/0", rsp_rdata_o, rsp_err_o); end
        complete_rsp();
    endtask

    task automatic test_out_of_range;
        issue(1'b1, 3'd7, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
                failures++;
                $display("FAIL oor_hold cyc=%0d got=%b/%b/%h exp=1/1/0", i, rsp_valid_o, rsp_err_o, rsp_rdata_o);
            end
            checks++;
            if (req_ready_o !== 1'b0) begin failures++; $display("FAIL oor_busy cyc=%0d got=%b exp=0", i, req_ready_o); end
            @(posedge clk); #1;
        end
        checks++;
        if (regs_o !== exp_regs || viol_cnt_o !== 16'd2) begin failures++; $display("FAIL oor_side got=%h/%0d exp=%h/2", regs_o, viol_cnt_o, exp_regs); end
        complete_rsp();
        issue(1'b0, 3'd6, 32'h0);
        checks++;
        if (rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin failures++; $display("FAIL oor_rd6 got=%b/%h exp=1/0", rsp_err_o, rsp_rdata_o); end
        complete_rsp();
    endtask

    task automatic test_reset_mid_txn;
        issue(1'b1, 3'd0, 32'hA5A5_0001);
        exp_regs[0] = 32'hA5A5_0001;
        checks++;
        if (regs_o !== exp_regs) begin failures++; $display("FAIL pre_rst_regs got=%h exp=%h", regs_o, exp_regs); end
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        exp_regs = '0;
        checks++;
        if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", rsp_valid_o); end
        checks++;
        if (regs_o !== exp_regs) begin failures++; $display("FAIL rst_resp_regs got=%h exp=%h", regs_o, exp_regs); end
        checks++;
        if (viol_cnt_o !== 16'd0 || viol_flag_o !== 1'b0 || s_cnt !== 2'd0) begin failures++; $display("FAIL rst_resp_viol got=%0d/%b/%0d exp=0/0/0", viol_cnt_o, viol_flag_o, s_cnt); end

        // Reset landing on the CHECK edge must drop the write.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 3'd2;
        req_wdata_i = 32'h55;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        rst_i       = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (regs_o !== exp_regs || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_check got=%h/%b/%b exp=%h/0/1", regs_o, rsp_valid_o, req_ready_o, exp_regs);
        end
    endtask

    task automatic test_saturation;
        reglk_mem[5] = 32'h1;
        dbg_i        = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            issue(1'b1, 3'd5, 32'h0000_0F00 + 32'(k));
            checks++;
            if (viol_cnt_o !== 16'(k) || rsp_err_o !== 1'b1) begin failures++; $display("FAIL sat_wide k=%0d got=%0d/%b exp=%0d/1", k, viol_cnt_o, rsp_err_o, k); end
            checks++;
            if (s_cnt !== ((k > 3) ? 2'd3 : 2'(k)) || s_rsp_err !== 1'b1 || s_flag !== 1'b1) begin
                failures++;
                $display("FAIL sat_narrow k=%0d got=%0d/%b/%b exp=%0d/1/1", k, s_cnt, s_rsp_err, s_flag, (k > 3) ? 3 : k);
            end
            checks++;
            if (regs_o !== exp_regs) begin failures++; $display("FAIL sat_regs k=%0d got=%h exp=%h", k, regs_o, exp_regs); end
            complete_rsp();
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_regs    = '0;
        rst_i       = 1'b1;
        reglk_mem   = '0;
        jtag_unlock = '0;
        dbg_i       = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;

        test_reset();
        test_read_after_reset();
        test_write_unlocked();
        test_locked_write();
        test_out_of_range();
        test_reset_mid_txn();
        test_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
